// File: rtl/mul_share_ctrl_if.sv
// Request/response/multiplier bundle between two requesters, the sharing controller and the array multiplier.
// master = requester/consumer/multiplier side, slave = mul_share_ctrl.
interface mul_share_ctrl_if #(
  parameter int DW = 8,
  parameter int MW = 4
);
  logic            req0_valid;
  logic            req0_ready;
  logic [DW-1:0]   req0_a;
  logic [DW-1:0]   req0_b;
  logic            req1_valid;
  logic            req1_ready;
  logic [DW-1:0]   req1_a;
  logic [DW-1:0]   req1_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_id;
  logic [2*DW-1:0] rsp_product;
  logic [MW-1:0]   mul_a;
  logic [MW-1:0]   mul_b;
  logic [2*MW-1:0] mul_result;

  modport master (
    output req0_valid, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_a, req1_b,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_product,
    output rsp_ready,
    input  mul_a, mul_b,
    output mul_result
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_a, req1_b,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_product,
    input  rsp_ready,
    output mul_a, mul_b,
    input  mul_result
  );
endinterface

// File: rtl/mul_share_ctrl.sv
// Round-robin sharing of one 4x4 multiplier for 8x8 multiplies; response 4 cycles after accept, one op per 6 cycles.
// Result held in RESP until rsp_ready; no request is accepted while a result is pending.
module mul_share_ctrl #(
  parameter int DW = 8,
  parameter int MW = 4
) (
  input logic           clk,
  input logic           rst_n,
  mul_share_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } opnd_t;

  state_t          state;
  logic [1:0]      step;
  opnd_t           opnd;
  logic [2*DW-1:0] acc;
  logic            last;
  logic            rsp_id_q;
  logic            rsp_valid_q;

  logic            grant;
  logic            accept;
  logic [MW-1:0]   nib_a;
  logic [MW-1:0]   nib_b;
  logic [2*DW-1:0] pp_shifted;

  // On contention the requester that did not win last time goes first.
  always_comb begin
    grant = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last;
    end
  end

  assign accept         = rst_n && (state == IDLE) && (bus.req0_valid || bus.req1_valid);
  assign bus.req0_ready = accept && !grant;
  assign bus.req1_ready = accept && grant;

  // step[0] picks the high nibble of a, step[1] the high nibble of b.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    if (rst_n && (state == MUL)) begin
      nib_a = step[0] ? opnd.a[DW-1:MW] : opnd.a[MW-1:0];
      nib_b = step[1] ? opnd.b[DW-1:MW] : opnd.b[MW-1:0];
    end
  end

  assign bus.mul_a = nib_a;
  assign bus.mul_b = nib_b;

  always_comb begin
    case (step)
      2'd0:    pp_shifted = {{DW{1'b0}}, bus.mul_result};
      2'd3:    pp_shifted = {bus.mul_result, {DW{1'b0}}};
      default: pp_shifted = {{MW{1'b0}}, bus.mul_result, {MW{1'b0}}};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      step        <= '0;
      opnd        <= '0;
      acc         <= '0;
      last        <= 1'b1;
      rsp_id_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (grant) begin
              opnd.a <= bus.req1_a;
              opnd.b <= bus.req1_b;
            end else begin
              opnd.a <= bus.req0_a;
              opnd.b <= bus.req0_b;
            end
            rsp_id_q <= grant;
            last     <= grant;
            acc      <= '0;
            step     <= '0;
            state    <= MUL;
          end
        end
        MUL: begin
          acc  <= acc + pp_shifted;
          step <= step + 2'd1;
          if (step == 2'd3) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_product = acc;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed + random bench for mul_share_ctrl; accepts push expected results, a monitor pops and compares on each response.
module tb_mul_share_ctrl;

  typedef struct packed {
    logic        id;
    logic [15:0] prod;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mul_share_ctrl_if bus ();

  mul_share_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External array multiplier model.
  assign bus.mul_result = 8'({4'b0, bus.mul_a} * {4'b0, bus.mul_b});

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_pop = 0;
  int   pop_base;
  bit   rand_done;

  int          arb_cyc;
  int          arb_nacc;
  int          arb_nrsp;
  int          acc_cyc[4];
  int          acc_id[4];
  logic [15:0] rsp_prod[4];
  logic        rsp_idv[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic scoreboard();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
          n_pop++;
          if (exp_q.size() == 0) begin
            check("sb_unexpected_rsp", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("sb_id", 32'(bus.rsp_id), 32'(e.id));
            check("sb_product", 32'(bus.rsp_product), 32'(e.prod));
          end
        end
        if (bus.req0_valid === 1'b1 && bus.req0_ready === 1'b1)
          exp_q.push_back({1'b0, {8'b0, bus.req0_a} * {8'b0, bus.req0_b}});
        if (bus.req1_valid === 1'b1 && bus.req1_ready === 1'b1)
          exp_q.push_back({1'b1, {8'b0, bus.req1_a} * {8'b0, bus.req1_b}});
      end
    end
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || bus.rsp_valid === 1'b1) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // seq packs {a0,b0,a1,b1,a2,b2,a3,b3} nibbles for steps 0..3.
  task automatic run_seq(input int port, input logic [7:0] a, input logic [7:0] b,
                         input logic [31:0] seq, input logic [15:0] prod, input string tag);
    @(posedge clk); #1;
    if (port == 0) begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
    end
    @(negedge clk);
    check({tag, "_ready0"}, 32'(bus.req0_ready), 32'(port == 0));
    check({tag, "_ready1"}, 32'(bus.req1_ready), 32'(port == 1));
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check({tag, "_mul_a"}, 32'(bus.mul_a), 32'(seq[31-8*i -: 4]));
      check({tag, "_mul_b"}, 32'(bus.mul_b), 32'(seq[27-8*i -: 4]));
      check({tag, "_early_valid"}, 32'(bus.rsp_valid), 32'd0);
    end
    @(negedge clk);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'(port));
    check({tag, "_rsp_product"}, 32'(bus.rsp_product), 32'(prod));
    drain({tag, "_drain"});
  endtask

  task automatic drive_port(input int port, input int n);
    logic [7:0] a;
    logic [7:0] b;
    logic       got;
    int         k;
    for (int i = 0; i < n; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      repeat ($urandom_range(2)) @(posedge clk);
      @(posedge clk); #1;
      if (port == 0) begin
        bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
      end else begin
        bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
      end
      got = 1'b0;
      k = 0;
      while (!got && k < 300) begin
        @(negedge clk);
        k++;
        got = (port == 0) ? bus.req0_ready : bus.req1_ready;
      end
      if (!got) check("rand_grant_timeout", 32'(got), 32'd1);
      @(posedge clk); #1;
      if (port == 0) bus.req0_valid = 1'b0;
      else           bus.req1_valid = 1'b0;
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_a     = 8'h00;
    bus.req0_b     = 8'h00;
    bus.req1_valid = 1'b0;
    bus.req1_a     = 8'h00;
    bus.req1_b     = 8'h00;
    bus.rsp_ready  = 1'b1;
    fork
      scoreboard();
    join_none

    // Reset state, with a request held to prove readies are gated.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("reset_rsp_product", 32'(bus.rsp_product), 32'd0);
    check("reset_req0_ready", 32'(bus.req0_ready), 32'd0);
    check("reset_mul_a", 32'(bus.mul_a), 32'd0);
    check("reset_mul_b", 32'(bus.mul_b), 32'd0);
    bus.req0_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_seq(0, 8'hFF, 8'hFF, 32'hFFFF_FFFF, 16'hFE01, "single");
    run_seq(1, 8'h12, 8'h34, 32'h2414_2313, 16'h03A8, "nibble");

    // Arbitration: both requesters valid straight out of reset.
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.req0_a = 8'd3; bus.req0_b = 8'd5; bus.req0_valid = 1'b1;
    bus.req1_a = 8'd7; bus.req1_b = 8'd9; bus.req1_valid = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    arb_cyc = 0; arb_nacc = 0; arb_nrsp = 0;
    while ((arb_nacc < 4 || arb_nrsp < 4) && arb_cyc < 60) begin
      @(negedge clk);
      arb_cyc++;
      if (arb_nacc < 4 && bus.req0_ready) begin
        acc_id[arb_nacc] = 0; acc_cyc[arb_nacc] = arb_cyc; arb_nacc++;
      end else if (arb_nacc < 4 && bus.req1_ready) begin
        acc_id[arb_nacc] = 1; acc_cyc[arb_nacc] = arb_cyc; arb_nacc++;
      end
      if (arb_nrsp < 4 && bus.rsp_valid) begin
        rsp_prod[arb_nrsp] = bus.rsp_product;
        rsp_idv[arb_nrsp]  = bus.rsp_id;
        arb_nrsp++;
      end
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check("arb_rsp_count", 32'(arb_nrsp), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("arb_grant_id", 32'(acc_id[i]), 32'(i % 2));
      check("arb_rsp_id", 32'(rsp_idv[i]), 32'(i % 2));
      check("arb_product", 32'(rsp_prod[i]), (i % 2 == 1) ? 32'd63 : 32'd15);
      if (i > 0) check("arb_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd6);
    end
    drain("arb_drain");

    // Backpressure: result held while req0 keeps asking.
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    bus.req0_a = 8'h0A; bus.req0_b = 8'h0B; bus.req0_valid = 1'b1;
    @(negedge clk);
    check("bp_accept", 32'(bus.req0_ready), 32'd1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_hold_product", 32'(bus.rsp_product), 32'h006E);
      check("bp_hold_id", 32'(bus.rsp_id), 32'd0);
      check("bp_hold_ready", 32'(bus.req0_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_handshake_ready", 32'(bus.req0_ready), 32'd0);
    @(negedge clk);
    check("bp_next_accept", 32'(bus.req0_ready), 32'd1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    drain("bp_drain");

    // Reset during step 2 discards the operation.
    @(posedge clk); #1;
    bus.req0_a = 8'h55; bus.req0_b = 8'h66; bus.req0_valid = 1'b1;
    @(negedge clk);
    check("rst_mid_accept", 32'(bus.req0_ready), 32'd1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_mul_a", 32'(bus.mul_a), 32'd0);
    check("rst_mid_mul_b", 32'(bus.mul_b), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_mid_product", 32'(bus.rsp_product), 32'd0);
    run_seq(0, 8'h00, 8'hAB, 32'h0B0B_0A0A, 16'h0000, "rst_next");

    // Random traffic on both ports with consumer stalls.
    rand_done = 1'b0;
    pop_base  = n_pop;
    fork
      begin
        fork
          drive_port(0, 128);
          drive_port(1, 128);
        join
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          bus.rsp_ready = ($urandom_range(3) != 0);
        end
        bus.rsp_ready = 1'b1;
      end
    join
    drain("rand_drain");
    check("rand_rsp_count", 32'(n_pop - pop_base), 32'd256);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mul_share_ctrl.md
Name: mul_share_ctrl

Overview:
- Sequencer and arbiter that lets two requesters share one combinational 4x4 array multiplier (4-bit A, 4-bit B, 8-bit Result).
- Each accepted request is an unsigned 8x8 multiply. The block splits it into four nibble partial products, feeds them through the shared multiplier over four cycles, and accumulates a 16-bit product.
- Sits between requester logic and the array multiplier instance. The multiplier itself stays external.

Parameters:
- DW, 8, operand width; fixed at 2 x 4 (two nibbles). Other values are unsupported.
- MW, 4, width of the shared multiplier's operands.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0's operation is accepted this cycle.
- req0_a  input  8  requester 0 multiplicand.
- req0_b  input  8  requester 0 multiplier.
- req1_valid  input  1  requester 1 has an operation pending.
- req1_ready  output  1  requester 1's operation is accepted this cycle.
- req1_a  input  8  requester 1 multiplicand.
- req1_b  input  8  requester 1 multiplier.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes the result.
- rsp_id  output  1  requester that owns the result (0/1).
- rsp_product  output  16  unsigned product.
- mul_a  output  4  operand A driven to the shared multiplier.
- mul_b  output  4  operand B driven to the shared multiplier.
- mul_result  input  8  shared multiplier product; combinational, valid in the same cycle.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at an edge):
  - state goes to IDLE; step=0; accumulator=0.
  - rsp_valid=0, rsp_id=0, rsp_product=0.
  - Round-robin pointer last=1, so requester 0 wins first.
  - Any in-flight operation is discarded with no response.
  - While rst_n=0, req0_ready=req1_ready=0 and mul_a=mul_b=0.
- FSM states: IDLE, MUL, RESP.
- IDLE:
  - Grant: if only one reqN_valid is high, that requester wins. If both are high, the requester != last wins.
  - reqN_ready=1 combinationally for the winner only; the other ready stays 0. Both readies are 0 outside IDLE.
  - At the accept edge: latch a and b, latch rsp_id=winner, set last=winner, clear the accumulator, step=0, go to MUL.
  - mul_a=mul_b=0 in IDLE.
- MUL, one cycle per step:
  - step0: mul_a=a[3:0], mul_b=b[3:0]; acc += mul_result.
  - step1: mul_a=a[7:4], mul_b=b[3:0]; acc += mul_result<<4.
  - step2: mul_a=a[3:0], mul_b=b[7:4]; acc += mul_result<<4.
  - step3: mul_a=a[7:4], mul_b=b[7:4]; acc += mul_result<<8.
  - Accumulator is 16 bits. The final sum never exceeds 0xFE01, so there is no overflow handling.
  - After the step3 edge: go to RESP, rsp_valid=1.
- Latency: accept at edge k; rsp_valid=1 from edge k+4.
- RESP:
  - rsp_product, rsp_id and rsp_valid are held stable until rsp_ready=1.
  - At the handshake edge: rsp_valid=0, go to IDLE. rsp_product keeps its last value until the next accept clears the accumulator.
  - No accept occurs in the same cycle as the handshake. Earliest next accept is edge k+6 when rsp_ready is held high, giving one operation per 6 cycles.
- Requester rules:
  - Requester inputs are ignored outside the accept cycle.
  - A requester may drop valid before it is granted; there is no obligation to hold.
  - A losing requester that keeps valid high is granted at the next IDLE accept, so neither requester starves.
- Pipeline: no pipelining and no queuing; there is a single operation in flight.

Test Plan:
- Single request: req0 a=0xFF, b=0xFF, valid at edge 0 -> req0_ready=1 in that cycle; rsp_valid=1 from edge 4 with rsp_product=0xFE01, rsp_id=0. mul_a/mul_b sequence is F/F, F/F, F/F, F/F.
- Nibble order: req1 a=0x12, b=0x34 -> mul_a/mul_b sequence 2/4, 1/4, 2/3, 1/3; rsp_product=0x03A8 (936), rsp_id=1.
- Arbitration: both valid continuously from reset with req0=(3,5), req1=(7,9), rsp_ready=1 -> responses alternate id 0,1,0,1 with products 15,63,15,63. Accepts are 6 cycles apart.
- Backpressure: after rsp_valid rises, hold rsp_ready=0 for 3 cycles with req0_valid high -> rsp_product/rsp_id stable, req0_ready=0 throughout; the next accept occurs the cycle after the handshake.
- Reset mid-operation: drive rst_n=0 for one edge during step2 -> rsp_valid stays 0, no response for that request, state IDLE. The next request (0x00, 0xAB) returns 0 with id 0.
- Random: 256 random operand pairs on both ports with random rsp_ready stalls -> every rsp_product equals a*b, rsp_id matches the issuing port, and no response is lost or duplicated.
